// File: rtl/vr_mmio_uart.sv
// Memory-mapped LED register plus FIFO-buffered 8N1 UART transmitter on the IO page.
// Optional macro VR_MMIO_LEDS_EN enables the LED register; without it o_LEDS is tied low.
module vr_mmio_uart #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_MEM_addr,
  input  logic        i_rEN,
  input  logic [31:0] i_MEM_wdata,
  input  logic [3:0]  i_wMASK,
  output logic [31:0] o_MEM_rdata,
  output logic        o_uart_tx,
  output logic [4:0]  o_LEDS
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_CNT = FIFO_DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   CNT_ONE   = 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = 1;
  localparam logic [15:0]      BIT_LAST  = CLKS_PER_BIT[15:0] - 16'd1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  logic             io_sel, wr_en, rd_en, data_wr, ov_clr, ov_set;
  logic [1:0]       reg_sel;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             fifo_empty, fifo_full, push, pop;
  state_t           state_reg, state_next;
  logic [15:0]      baud_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       tx_byte_reg;
  logic             baud_last, busy, overflow_reg, uart_tx;
  logic [31:0]      rdata_reg, rdata_next;
  logic [4:0]       leds;
  logic             unused_bits;

  assign unused_bits = ^{i_MEM_addr[31:23], i_MEM_addr[21:4], i_MEM_addr[1:0], i_MEM_wdata[31:8]};

  // Bus decode; anything coincident with reset is ignored.
  assign io_sel  = i_MEM_addr[22];
  assign reg_sel = i_MEM_addr[3:2];
  assign wr_en   = io_sel && (i_wMASK != 4'd0) && !i_rst;
  assign rd_en   = io_sel && i_rEN && !i_rst;
  assign data_wr = wr_en && (reg_sel == 2'b01);
  assign ov_clr  = rd_en && (reg_sel == 2'b10);

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == DEPTH_CNT);
  assign baud_last  = (baud_cnt_reg == BIT_LAST);
  assign busy       = !fifo_empty || (state_reg != ST_IDLE);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign pop    = !fifo_empty && !i_rst &&
                  ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && baud_last));
  assign push   = data_wr && (!fifo_full || pop);
  assign ov_set = data_wr && fifo_full && !pop;

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= i_MEM_wdata[7:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (push && !pop)      count_reg <= count_reg + CNT_ONE;
      else if (pop && !push) count_reg <= count_reg - CNT_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      tx_byte_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == ST_IDLE) || baud_last) baud_cnt_reg <= '0;
      else                                     baud_cnt_reg <= baud_cnt_reg + 16'd1;
      if ((state_reg == ST_DATA) && baud_last) bit_idx_reg <= bit_idx_reg + 3'd1;
      if (pop) tx_byte_reg <= fifo_mem[rd_ptr_reg];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (!fifo_empty) state_next = ST_START;
      ST_START: if (baud_last) state_next = ST_DATA;
      ST_DATA:  if (baud_last && (bit_idx_reg == 3'd7)) state_next = ST_STOP;
      ST_STOP:  if (baud_last) state_next = fifo_empty ? ST_IDLE : ST_START;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    case (state_reg)
      ST_START: uart_tx = 1'b0;
      ST_DATA:  uart_tx = tx_byte_reg[bit_idx_reg];
      default:  uart_tx = 1'b1;
    endcase
  end

  // Set wins over the read-triggered clear.
  always_ff @(posedge i_clk) begin
    if (i_rst)       overflow_reg <= 1'b0;
    else if (ov_set) overflow_reg <= 1'b1;
    else if (ov_clr) overflow_reg <= 1'b0;
  end

  always_comb begin
    rdata_next = '0;
    case (reg_sel)
      2'b00:   rdata_next = {27'd0, leds};
      2'b10:   rdata_next = {29'd0, overflow_reg, fifo_full, busy};
      default: rdata_next = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)      rdata_reg <= '0;
    else if (rd_en) rdata_reg <= rdata_next;
  end

`ifdef VR_MMIO_LEDS_EN
  logic [4:0] leds_reg;
  always_ff @(posedge i_clk) begin
    if (i_rst)                           leds_reg <= '0;
    else if (wr_en && (reg_sel == 2'b00)) leds_reg <= i_MEM_wdata[4:0];
  end
  assign leds = leds_reg;
`else
  assign leds = '0;
`endif

  assign o_MEM_rdata = rdata_reg;
  assign o_uart_tx   = uart_tx;
  assign o_LEDS      = leds;
endmodule

// File: doc/vr_mmio_uart.md
VR_MMIO_UART -- requirements
Module: vr_mmio_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, TX FIFO entries (power of two, 2..16).
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_MEM_addr  input  32  processor byte address.
REQ-006 SHALL have port i_rEN  input  1  processor read strobe.
REQ-007 SHALL have port i_MEM_wdata  input  32  processor write data.
REQ-008 SHALL have port i_wMASK  input  4  processor byte write mask.
REQ-009 SHALL have port o_MEM_rdata  output  32  registered read data for IO page.
REQ-010 SHALL have port o_uart_tx  output  1  UART serial line, idle high.
REQ-011 SHALL have port o_LEDS  output  5  LED register.

Function
REQ-012 IO page selected iff i_MEM_addr[22]=1; register select is i_MEM_addr[3:2]: 00 LEDS, 01 UART_DATA, 10 UART_STATUS, 11 reserved.
REQ-013 Write occurs in any cycle with IO page selected and i_wMASK != 0; byte lanes other than [7:0] are ignored.
REQ-014 Read: with IO page selected and i_rEN=1, o_MEM_rdata SHALL present the register one cycle later and hold until the next selected read; reserved and UART_DATA read as 0.
REQ-015 UART_STATUS = {29'b0, overflow, full, busy}; busy = FIFO not empty or TX FSM not IDLE.
REQ-016 A UART_DATA write when FIFO not full pushes i_MEM_wdata[7:0]; when full, data is dropped and sticky overflow is set.
REQ-017 overflow SHALL clear on the cycle after a selected UART_STATUS read, and the read returns the pre-clear value; a set and a clear in the same cycle leave it set.
REQ-018 Push and pop in the same cycle SHALL both take effect, including when full (pop frees the slot first).
REQ-019 TX FSM states IDLE, START, DATA, STOP; 8N1 format, LSB first, each bit held exactly CLKS_PER_BIT cycles.
REQ-020 IDLE with FIFO not empty: pop and enter START in the next cycle (o_uart_tx=0).
REQ-021 DATA: 8 bits from a 3-bit index; after bit 7 enter STOP (o_uart_tx=1).
REQ-022 End of STOP: if FIFO not empty, pop and enter START directly (no idle gap); else IDLE.
REQ-023 Write to LEDS loads o_LEDS <= i_MEM_wdata[4:0]; reads return {27'b0, o_LEDS}.

Reset
REQ-024 While i_rst=1 at a clock edge: o_uart_tx=1, FSM IDLE, FIFO empty, overflow=0, o_LEDS=0, o_MEM_rdata=0, bit counters 0.
REQ-025 Reset mid-frame SHALL abort the frame; o_uart_tx is 1 after that edge; FIFO contents are discarded.
REQ-026 Writes and reads coincident with i_rst=1 SHALL be ignored.

Configuration
REQ-027 Macro VR_MMIO_LEDS_EN: defined -> LEDS register present per REQ-023; undefined -> o_LEDS tied to 0, LEDS writes ignored, LEDS reads return 0.

Verification (bench CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Write 0x400004 data 0x41 -> o_uart_tx low 4 cycles, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high 4 cycles; busy=1 throughout, 0 after.
REQ-029 Five writes to 0x400004 (0x01..0x05) while idle -> first popped immediately, remaining four fill the FIFO, none dropped; frames transmitted back-to-back with no gap, 40 cycles per frame.
REQ-030 Six rapid writes -> sixth dropped; status read at 0x400008 returns 0x7, next status read returns 0x3.
REQ-031 Read 0x400008 with i_rEN while idle -> o_MEM_rdata=0 one cycle later; read 0x40000C -> 0.
REQ-032 Assert i_rst in the third data bit of a frame -> o_uart_tx=1 next cycle, status=0, no further frames.
REQ-033 With VR_MMIO_LEDS_EN, write 0x400000 data 0x1F -> o_LEDS=5'h1F, readback 0x1F; without it -> o_LEDS=0, readback 0.
